pm_stream_loader: RTL
=====================

// Module: pm_stream_loader
// PURPOSE
//   Writer side of the CPU program-memory load port. Accepts a byte stream over a valid/ready
//   handshake and drives pmWrEn / pm_addr / instructionIn into the pipelined CPU's program memory.
//   Holds the CPU in reset (cpu_rst) until a complete image has been written, then releases it.
//   Sits between the chip I/O byte interface and the CPU top; one byte is written per accepted beat.
// PARAMETERS
//   ADD_WIDTH  7      program-memory byte address width; capacity = 2**ADD_WIDTH bytes
//   WIDTH      8      byte/data width of stream and program memory write data
//   TIMEOUT    255    max idle cycles between beats in LOAD before abort (>=1)
// PORTS
//   clk            in   1            system clock, all logic rising-edge
//   rst            in   1            synchronous, active-high reset
//   start          in   1            single-cycle request to begin a load (sampled in IDLE/RUN only)
//   len            in   ADD_WIDTH+1  image length in bytes, sampled with start; legal 1..2**ADD_WIDTH
//   in_data        in   WIDTH        stream byte
//   in_valid       in   1            stream byte valid
//   in_ready       out  1            loader can accept a byte this cycle
//   pmWrEn         out  1            program-memory write enable (registered)
//   pm_addr        out  ADD_WIDTH    program-memory write address (registered)
//   instructionIn  out  WIDTH        program-memory write data (registered)
//   cpu_rst        out  1            CPU reset hold, active-high
//   busy           out  1            1 while in LOAD or FLUSH
//   done           out  1            one-cycle pulse on image completion
//   err            out  1            one-cycle pulse on illegal len or timeout
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=0, pmWrEn=0, pm_addr=0, instructionIn=0, cpu_rst=1, busy=0,
//     done=0, err=0; byte counter and timeout counter cleared. rst mid-load aborts with no done/err.
//   States: IDLE, LOAD, FLUSH, RUN.
//   IDLE: cpu_rst=1. start with 1<=len<=2**ADD_WIDTH -> LOAD, latch len, count=0.
//     start with len==0 or len>2**ADD_WIDTH -> err pulse next cycle, stay IDLE.
//   LOAD: in_ready=1 combinationally from state. Beat = in_valid & in_ready.
//     On beat: next cycle pmWrEn=1, pm_addr=count, instructionIn=in_data; count++.
//     Latency: byte accepted in cycle N is written (pmWrEn high) in cycle N+1.
//     Back-to-back beats give back-to-back writes; no beat -> pmWrEn=0 next cycle.
//     Beat with count==len-1 -> FLUSH (in_ready=0 from next cycle).
//     Timeout counter clears on every beat, increments otherwise; reaching TIMEOUT -> err pulse,
//       IDLE, cpu_rst stays 1, partial image left in memory.
//     start while in LOAD is ignored.
//   FLUSH: one cycle; final write is on the bus; done pulses in this cycle's successor
//     (i.e. done=1 coincident with entry to RUN). -> RUN.
//   RUN: cpu_rst=0, in_ready=0, pmWrEn=0. start (legal len) -> LOAD with cpu_rst=1 the very
//     next cycle; illegal len -> err pulse, remain RUN, CPU undisturbed.
//   Byte order: image byte k goes to address k; 32-bit instruction i occupies addresses 4i..4i+3,
//     little-endian (addr 4i = instruction[7:0]). Loader does not enforce len%4==0.
//   Addresses never wrap: len limit guarantees count <= 2**ADD_WIDTH-1 on last write.
//   done and err are never high in the same cycle; busy = (state==LOAD)|(state==FLUSH).
// STRUCTURE
//   Shared package pm_loader_pkg: state enum (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2, RUN=2'd3),
//     LEN_MAX = 2**ADD_WIDTH constant function.
//   Sub-module pm_loader_timeout: saturating idle counter, inputs clr/en, output expired.
//   Top holds FSM, byte counter, registered write-port outputs.
// TESTING
//   Reset, no stimulus 10 cycles -> cpu_rst=1, pmWrEn=0, in_ready=0, done=err=0.
//   start len=8, 8 back-to-back bytes 0x13,0x00,0x10,0x00,... -> 8 consecutive pmWrEn cycles,
//     pm_addr 0..7, data matches, done pulse once, cpu_rst falls same cycle as done.
//   start len=4, in_valid toggled every other cycle -> writes only on beat+1, addr 0..3, done once.
//   start len=0 and len=129 (ADD_WIDTH=7) -> err pulse, no pmWrEn, state/cpu_rst unchanged.
//   start len=4, send 2 bytes then stall TIMEOUT cycles -> err pulse, cpu_rst=1, no done.
//   rst asserted after 3 of 6 bytes -> all outputs at reset values next cycle; then full
//     len=128 load -> last write pm_addr=127, done, no address wrap.

Source files
------------

// File: rtl/pm_loader_pkg.sv
// Shared definitions for the program-memory stream loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pm_loader_pkg;

  // Loader FSM states; encodings are fixed so external debug taps can decode them.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Largest legal image length in bytes for a given address width.
  function automatic int len_max(input int add_width);
    return 1 << add_width;
  endfunction

endpackage

// File: rtl/pm_loader_timeout.sv
// Idle-cycle watchdog for the LOAD phase: counts consecutive cycles without a beat.
// Latency: expired is combinational from the current count and en.
// Backpressure: none; clr has priority over en, the count saturates at TIMEOUT-1.
module pm_loader_timeout
  import pm_loader_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The TIMEOUT-th consecutive idle cycle is the one that sees LAST with en high.
  assign expired = en & (cnt_q == LAST);

  // Next count: clear on request, otherwise advance on idle cycles until LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pm_stream_loader.sv
// Streams an image byte-by-byte into CPU program memory and holds the CPU in reset until it is complete.
// Latency: a byte accepted in cycle N appears on the write port in cycle N+1; done follows the last write by one cycle.
// Backpressure: in_ready is high only in LOAD; the loader never stalls a beat it has offered to take.
module pm_stream_loader
  import pm_loader_pkg::*;
#(
  parameter int ADD_WIDTH = 7,
  parameter int WIDTH     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_WIDTH:0]   len,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 pmWrEn,
  output logic [ADD_WIDTH-1:0] pm_addr,
  output logic [WIDTH-1:0]     instructionIn,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [ADD_WIDTH:0] LEN_LIMIT = (ADD_WIDTH + 1)'(len_max(ADD_WIDTH));
  localparam logic [ADD_WIDTH:0] ONE       = (ADD_WIDTH + 1)'(1);

  state_e               state_q, state_d;
  logic [ADD_WIDTH:0]   len_q, len_d;
  logic [ADD_WIDTH:0]   count_q, count_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADD_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic beat;
  logic len_ok;
  logic to_clr;
  logic to_en;
  logic to_expired;

  assign in_ready = (state_q == LOAD);
  assign beat     = in_valid & in_ready;
  assign len_ok   = (len != '0) && (len <= LEN_LIMIT);

  // Any beat, or being outside LOAD, restarts the idle count so each load starts fresh.
  assign to_clr = (state_q != LOAD) | beat;
  assign to_en  = (state_q == LOAD) & ~beat;

  pm_loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .en     (to_en),
    .expired(to_expired)
  );

  // Next-state, byte counter and write-port next values.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        // An illegal request leaves the state alone, so a running CPU keeps running.
        if (start) begin
          if (len_ok) begin
            state_d = LOAD;
            len_d   = len;
            count_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en_d = 1'b1;
          addr_d  = count_q[ADD_WIDTH-1:0];
          data_d  = in_data;
          count_d = count_q + ONE;
          if (count_q == (len_q - ONE)) begin
            state_d = FLUSH;
          end
        end else if (to_expired) begin
          // Partial image stays in memory; the CPU stays in reset.
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      FLUSH: begin
        state_d = RUN;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered write-port / pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pmWrEn        = wr_en_q;
  assign pm_addr       = addr_q;
  assign instructionIn = data_q;
  assign cpu_rst       = (state_q != RUN);
  assign busy          = (state_q == LOAD) || (state_q == FLUSH);
  assign done          = done_q;
  assign err           = err_q;

endmodule
